// File: rtl/axil_bus_router.sv
// AXI4-Lite 1-to-N router: one upstream slave port fans out to NUM_SLAVES master ports
// selected by an address field, with local DECERR for unmapped targets and a DECERR counter.
module axil_bus_router #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 2,
  parameter int NUM_SLAVES = 2,
  parameter int SEL_LSB    = 4,
  parameter int SEL_BITS   = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             s0_axi_aclk,
  input  logic                             s0_axi_areset,
  input  logic [ADDR_WIDTH-1:0]            s0_axi_awaddr,
  input  logic                             s0_axi_awvalid,
  output logic                             s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]            s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]          s0_axi_wstrb,
  input  logic                             s0_axi_wvalid,
  output logic                             s0_axi_wready,
  output logic [RESP_WIDTH-1:0]            s0_axi_bresp,
  output logic                             s0_axi_bvalid,
  input  logic                             s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]            s0_axi_araddr,
  input  logic                             s0_axi_arvalid,
  output logic                             s0_axi_arready,
  output logic [DATA_WIDTH-1:0]            s0_axi_rdata,
  output logic [RESP_WIDTH-1:0]            s0_axi_rresp,
  output logic                             s0_axi_rvalid,
  input  logic                             s0_axi_rready,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [NUM_SLAVES-1:0]            m_axi_awvalid,
  input  logic [NUM_SLAVES-1:0]            m_axi_awready,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0] m_axi_wdata,
  output logic [NUM_SLAVES*DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic [NUM_SLAVES-1:0]            m_axi_wvalid,
  input  logic [NUM_SLAVES-1:0]            m_axi_wready,
  input  logic [NUM_SLAVES*RESP_WIDTH-1:0] m_axi_bresp,
  input  logic [NUM_SLAVES-1:0]            m_axi_bvalid,
  output logic [NUM_SLAVES-1:0]            m_axi_bready,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [NUM_SLAVES-1:0]            m_axi_arvalid,
  input  logic [NUM_SLAVES-1:0]            m_axi_arready,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [NUM_SLAVES*RESP_WIDTH-1:0] m_axi_rresp,
  input  logic [NUM_SLAVES-1:0]            m_axi_rvalid,
  output logic [NUM_SLAVES-1:0]            m_axi_rready,
  output logic [CNT_WIDTH-1:0]             decerr_count
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [RESP_WIDTH-1:0] RESP_DECERR = RESP_WIDTH'(3);

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAITB, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAITR, R_RESP} r_state_t;

  // One-hot target mask; all zeros means the address is unmapped.
  function automatic logic [NUM_SLAVES-1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
    decode = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (addr[SEL_LSB +: SEL_BITS] == SEL_BITS'(i)) decode[i] = 1'b1;
  endfunction

  w_state_t                w_state;
  logic                    aw_held, w_held, aw_done, w_done;
  logic                    awready_q, wready_q, bvalid_q;
  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic [RESP_WIDTH-1:0]   bresp_q;
  logic [NUM_SLAVES-1:0]   wmask, awvalid_q, wvalid_q, bready_q;

  r_state_t                r_state;
  logic                    arready_q, rvalid_q;
  logic [ADDR_WIDTH-1:0]   araddr_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [RESP_WIDTH-1:0]   rresp_q;
  logic [NUM_SLAVES-1:0]   rmask, arvalid_q, rready_q;

  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [CNT_WIDTH:0]      cnt_sum;
  logic [1:0]              dec_inc;

  logic                    aw_fire, w_fire, aw_have, w_have, aw_hs, w_hs, b_hs;
  logic                    ar_fire, ar_hs, r_hs;
  logic [ADDR_WIDTH-1:0]   aw_addr_cur;
  logic [NUM_SLAVES-1:0]   w_dec, ar_dec;
  logic [RESP_WIDTH-1:0]   bresp_sel, rresp_sel;
  logic [DATA_WIDTH-1:0]   rdata_sel;

  assign aw_fire     = s0_axi_awvalid & awready_q;
  assign w_fire      = s0_axi_wvalid & wready_q;
  assign aw_have     = aw_held | aw_fire;
  assign w_have      = w_held | w_fire;
  assign aw_addr_cur = aw_held ? awaddr_q : s0_axi_awaddr;
  assign w_dec       = decode(aw_addr_cur);
  assign aw_hs       = |(awvalid_q & m_axi_awready);
  assign w_hs        = |(wvalid_q & m_axi_wready);
  assign b_hs        = |(bready_q & m_axi_bvalid);
  assign ar_fire     = s0_axi_arvalid & arready_q;
  assign ar_dec      = decode(s0_axi_araddr);
  assign ar_hs       = |(arvalid_q & m_axi_arready);
  assign r_hs        = |(rready_q & m_axi_rvalid);

  always_comb begin
    bresp_sel = '0;
    rresp_sel = '0;
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (wmask[i]) bresp_sel = m_axi_bresp[i*RESP_WIDTH +: RESP_WIDTH];
      if (rmask[i]) begin
        rresp_sel = m_axi_rresp[i*RESP_WIDTH +: RESP_WIDTH];
        rdata_sel = m_axi_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Write engine: AW and W are collected independently, then issued together downstream.
  always_ff @(posedge s0_axi_aclk) begin
    if (s0_axi_areset) begin
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wmask     <= '0;
      awvalid_q <= '0;
      wvalid_q  <= '0;
      bready_q  <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_fire) begin
            aw_held  <= 1'b1;
            awaddr_q <= s0_axi_awaddr;
          end
          if (w_fire) begin
            w_held  <= 1'b1;
            wdata_q <= s0_axi_wdata;
            wstrb_q <= s0_axi_wstrb;
          end
          awready_q <= !aw_have;
          wready_q  <= !w_have;
          if (aw_have && w_have) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            wmask   <= w_dec;
            if (|w_dec) begin
              awvalid_q <= w_dec;
              wvalid_q  <= w_dec;
              aw_done   <= 1'b0;
              w_done    <= 1'b0;
              w_state   <= W_ISSUE;
            end else begin
              bvalid_q <= 1'b1;
              bresp_q  <= RESP_DECERR;
              w_state  <= W_RESP;
            end
          end
        end
        W_ISSUE: begin
          if (aw_hs) begin
            awvalid_q <= '0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= '0;
            w_done   <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            bready_q <= wmask;
            w_state  <= W_WAITB;
          end
        end
        W_WAITB: begin
          if (b_hs) begin
            bready_q <= '0;
            bvalid_q <= 1'b1;
            bresp_q  <= bresp_sel;
            w_state  <= W_RESP;
          end
        end
        W_RESP: begin
          if (s0_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read engine: single outstanding AR, response buffered until the upstream accepts it.
  always_ff @(posedge s0_axi_aclk) begin
    if (s0_axi_areset) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      araddr_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rmask     <= '0;
      arvalid_q <= '0;
      rready_q  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ar_fire) begin
            arready_q <= 1'b0;
            araddr_q  <= s0_axi_araddr;
            rmask     <= ar_dec;
            if (|ar_dec) begin
              arvalid_q <= ar_dec;
              r_state   <= R_ISSUE;
            end else begin
              rvalid_q <= 1'b1;
              rresp_q  <= RESP_DECERR;
              rdata_q  <= '0;
              r_state  <= R_RESP;
            end
          end
        end
        R_ISSUE: begin
          if (ar_hs) begin
            arvalid_q <= '0;
            rready_q  <= rmask;
            r_state   <= R_WAITR;
          end
        end
        R_WAITR: begin
          if (r_hs) begin
            rready_q <= '0;
            rvalid_q <= 1'b1;
            rresp_q  <= rresp_sel;
            rdata_q  <= rdata_sel;
            r_state  <= R_RESP;
          end
        end
        R_RESP: begin
          if (s0_axi_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state   <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Counts DECERR responses as they are accepted upstream, saturating at all-ones.
  assign dec_inc = {1'b0, (bvalid_q && s0_axi_bready && bresp_q == RESP_DECERR)}
                 + {1'b0, (rvalid_q && s0_axi_rready && rresp_q == RESP_DECERR)};
  assign cnt_sum = {1'b0, cnt_q} + (CNT_WIDTH+1)'(dec_inc);

  always_ff @(posedge s0_axi_aclk) begin
    if (s0_axi_areset) cnt_q <= '0;
    else if (cnt_sum[CNT_WIDTH]) cnt_q <= '1;
    else cnt_q <= cnt_sum[CNT_WIDTH-1:0];
  end

  assign s0_axi_awready = awready_q;
  assign s0_axi_wready  = wready_q;
  assign s0_axi_bvalid  = bvalid_q;
  assign s0_axi_bresp   = bresp_q;
  assign s0_axi_arready = arready_q;
  assign s0_axi_rvalid  = rvalid_q;
  assign s0_axi_rresp   = rresp_q;
  assign s0_axi_rdata   = rdata_q;
  assign m_axi_awvalid  = awvalid_q;
  assign m_axi_wvalid   = wvalid_q;
  assign m_axi_bready   = bready_q;
  assign m_axi_arvalid  = arvalid_q;
  assign m_axi_rready   = rready_q;
  assign decerr_count   = cnt_q;

  // Payloads appear only on the port whose valid is raised, keeping idle ports at zero.
  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_port
    assign m_axi_awaddr[g*ADDR_WIDTH +: ADDR_WIDTH] = awvalid_q[g] ? awaddr_q : '0;
    assign m_axi_wdata[g*DATA_WIDTH +: DATA_WIDTH]  = wvalid_q[g] ? wdata_q : '0;
    assign m_axi_wstrb[g*STRB_WIDTH +: STRB_WIDTH]  = wvalid_q[g] ? wstrb_q : '0;
    assign m_axi_araddr[g*ADDR_WIDTH +: ADDR_WIDTH] = arvalid_q[g] ? araddr_q : '0;
  end

endmodule

// File: tb/tb_axil_bus_router.sv
// Directed bench for axil_bus_router: cycle-exact checks of routing, DECERR, stalls and reset.
module tb_axil_bus_router;

  logic        clk;
  logic        reset;
  logic [7:0]  s0_awaddr;
  logic        s0_awvalid, s0_awready;
  logic [31:0] s0_wdata;
  logic [3:0]  s0_wstrb;
  logic        s0_wvalid, s0_wready;
  logic [1:0]  s0_bresp;
  logic        s0_bvalid, s0_bready;
  logic [7:0]  s0_araddr;
  logic        s0_arvalid, s0_arready;
  logic [31:0] s0_rdata;
  logic [1:0]  s0_rresp;
  logic        s0_rvalid, s0_rready;
  logic [15:0] m_awaddr;
  logic [1:0]  m_awvalid, m_awready;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic [1:0]  m_wvalid, m_wready;
  logic [3:0]  m_bresp;
  logic [1:0]  m_bvalid, m_bready;
  logic [15:0] m_araddr;
  logic [1:0]  m_arvalid, m_arready;
  logic [63:0] m_rdata;
  logic [3:0]  m_rresp;
  logic [1:0]  m_rvalid, m_rready;
  logic [15:0] decerr_count;

  int compared = 0;
  int mismatched = 0;

  axil_bus_router dut (
    .s0_axi_aclk(clk), .s0_axi_areset(reset),
    .s0_axi_awaddr(s0_awaddr), .s0_axi_awvalid(s0_awvalid), .s0_axi_awready(s0_awready),
    .s0_axi_wdata(s0_wdata), .s0_axi_wstrb(s0_wstrb), .s0_axi_wvalid(s0_wvalid),
    .s0_axi_wready(s0_wready),
    .s0_axi_bresp(s0_bresp), .s0_axi_bvalid(s0_bvalid), .s0_axi_bready(s0_bready),
    .s0_axi_araddr(s0_araddr), .s0_axi_arvalid(s0_arvalid), .s0_axi_arready(s0_arready),
    .s0_axi_rdata(s0_rdata), .s0_axi_rresp(s0_rresp), .s0_axi_rvalid(s0_rvalid),
    .s0_axi_rready(s0_rready),
    .m_axi_awaddr(m_awaddr), .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wvalid(m_wvalid),
    .m_axi_wready(m_wready),
    .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
    .m_axi_araddr(m_araddr), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
    .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rvalid(m_rvalid),
    .m_axi_rready(m_rready),
    .decerr_count(decerr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1;
    s0_awaddr = '0; s0_awvalid = 0; s0_wdata = '0; s0_wstrb = '0; s0_wvalid = 0;
    s0_bready = 0; s0_araddr = '0; s0_arvalid = 0; s0_rready = 0;
    m_awready = '0; m_wready = '0; m_bresp = '0; m_bvalid = '0;
    m_arready = '0; m_rdata = '0; m_rresp = '0; m_rvalid = '0;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_awready", 64'(s0_awready), 64'h0);
    checkOutput("rst_arready", 64'(s0_arready), 64'h0);
    checkOutput("rst_bvalid", 64'(s0_bvalid), 64'h0);
    checkOutput("rst_rvalid", 64'(s0_rvalid), 64'h0);
    checkOutput("rst_count", 64'(decerr_count), 64'h0);
    reset = 1'b0;
    applyStimulus();
    checkOutput("idle_awready", 64'(s0_awready), 64'h1);
    checkOutput("idle_wready", 64'(s0_wready), 64'h1);
    checkOutput("idle_arready", 64'(s0_arready), 64'h1);

    $display("[TB] write 0xDEADBEEF to 0x14, AW and W together");
    m_awready = 2'b11; m_wready = 2'b11; m_bvalid = 2'b11; m_bresp = 4'b0000;
    s0_bready = 1;
    s0_awaddr = 8'h14; s0_awvalid = 1; s0_wdata = 32'hDEADBEEF; s0_wstrb = 4'hF; s0_wvalid = 1;
    applyStimulus();
    s0_awvalid = 0; s0_wvalid = 0;
    checkOutput("w1_awvalid", 64'(m_awvalid), 64'h2);
    checkOutput("w1_wvalid", 64'(m_wvalid), 64'h2);
    checkOutput("w1_awaddr", 64'(m_awaddr), 64'h1400);
    checkOutput("w1_wdata", m_wdata, 64'hDEADBEEF_00000000);
    checkOutput("w1_wstrb", 64'(m_wstrb), 64'hF0);
    checkOutput("w1_bvalid_t1", 64'(s0_bvalid), 64'h0);
    applyStimulus();
    checkOutput("w1_bready", 64'(m_bready), 64'h2);
    checkOutput("w1_awvalid_t2", 64'(m_awvalid), 64'h0);
    applyStimulus();
    checkOutput("w1_bvalid_t3", 64'(s0_bvalid), 64'h1);
    checkOutput("w1_bresp", 64'(s0_bresp), 64'h0);
    applyStimulus();
    checkOutput("w1_bvalid_t4", 64'(s0_bvalid), 64'h0);
    checkOutput("w1_awready_t4", 64'(s0_awready), 64'h1);

    $display("[TB] W leads AW by 3 cycles, port 0 returns SLVERR");
    m_bresp = 4'b0010;
    s0_wdata = 32'hCAFEF00D; s0_wstrb = 4'h3; s0_wvalid = 1;
    applyStimulus();
    s0_wvalid = 0;
    checkOutput("w2_wready_held", 64'(s0_wready), 64'h0);
    checkOutput("w2_no_issue", 64'(m_wvalid), 64'h0);
    applyStimulus();
    applyStimulus();
    s0_awaddr = 8'h04; s0_awvalid = 1;
    checkOutput("w2_no_issue_late", 64'(m_awvalid), 64'h0);
    applyStimulus();
    s0_awvalid = 0;
    checkOutput("w2_awvalid", 64'(m_awvalid), 64'h1);
    checkOutput("w2_wvalid", 64'(m_wvalid), 64'h1);
    checkOutput("w2_awaddr", 64'(m_awaddr), 64'h0004);
    checkOutput("w2_wdata", m_wdata, 64'h00000000_CAFEF00D);
    checkOutput("w2_wstrb", 64'(m_wstrb), 64'h03);
    applyStimulus();
    checkOutput("w2_bready", 64'(m_bready), 64'h1);
    applyStimulus();
    checkOutput("w2_bvalid", 64'(s0_bvalid), 64'h1);
    checkOutput("w2_bresp_slverr", 64'(s0_bresp), 64'h2);
    applyStimulus();
    checkOutput("w2_bvalid_pulse", 64'(s0_bvalid), 64'h0);
    checkOutput("w2_count", 64'(decerr_count), 64'h0);
    m_bresp = 4'b0000;

    $display("[TB] read 0x18 with arready stalls and 5 wait cycles");
    m_arready = 2'b00; m_rvalid = 2'b00; s0_rready = 1;
    s0_araddr = 8'h18; s0_arvalid = 1;
    checkOutput("r1_arready", 64'(s0_arready), 64'h1);
    applyStimulus();
    s0_arvalid = 0;
    checkOutput("r1_arvalid", 64'(m_arvalid), 64'h2);
    checkOutput("r1_araddr", 64'(m_araddr), 64'h1800);
    applyStimulus();
    checkOutput("r1_arvalid_stall1", 64'(m_arvalid), 64'h2);
    applyStimulus();
    checkOutput("r1_arvalid_stall2", 64'(m_arvalid), 64'h2);
    m_arready = 2'b10;
    applyStimulus();
    m_arready = 2'b00;
    checkOutput("r1_arvalid_done", 64'(m_arvalid), 64'h0);
    checkOutput("r1_rready", 64'(m_rready), 64'h2);
    repeat (5) applyStimulus();
    checkOutput("r1_rready_wait", 64'(m_rready), 64'h2);
    checkOutput("r1_rvalid_wait", 64'(s0_rvalid), 64'h0);
    m_rvalid = 2'b10; m_rdata = {32'h12345678, 32'hFFFFFFFF}; m_rresp = 4'b0011;
    applyStimulus();
    m_rvalid = 2'b00;
    checkOutput("r1_rvalid", 64'(s0_rvalid), 64'h1);
    checkOutput("r1_rdata", 64'(s0_rdata), 64'h12345678);
    checkOutput("r1_rresp", 64'(s0_rresp), 64'h0);
    checkOutput("r1_rready_off", 64'(m_rready), 64'h0);
    applyStimulus();
    checkOutput("r1_rvalid_off", 64'(s0_rvalid), 64'h0);
    checkOutput("r1_arready_back", 64'(s0_arready), 64'h1);

    $display("[TB] read 0x30 unmapped");
    s0_araddr = 8'h30; s0_arvalid = 1;
    applyStimulus();
    s0_arvalid = 0;
    checkOutput("r2_rvalid", 64'(s0_rvalid), 64'h1);
    checkOutput("r2_rresp", 64'(s0_rresp), 64'h3);
    checkOutput("r2_rdata", 64'(s0_rdata), 64'h0);
    checkOutput("r2_no_arvalid", 64'(m_arvalid), 64'h0);
    applyStimulus();
    checkOutput("r2_count", 64'(decerr_count), 64'h1);

    $display("[TB] simultaneous write 0x20 and read 0x30, both unmapped");
    s0_awaddr = 8'h20; s0_awvalid = 1; s0_wdata = 32'h0; s0_wstrb = 4'hF; s0_wvalid = 1;
    s0_araddr = 8'h30; s0_arvalid = 1;
    applyStimulus();
    s0_awvalid = 0; s0_wvalid = 0; s0_arvalid = 0;
    checkOutput("d2_bvalid", 64'(s0_bvalid), 64'h1);
    checkOutput("d2_bresp", 64'(s0_bresp), 64'h3);
    checkOutput("d2_rresp", 64'(s0_rresp), 64'h3);
    checkOutput("d2_no_mvalid", 64'({m_awvalid, m_wvalid, m_arvalid}), 64'h0);
    applyStimulus();
    checkOutput("d2_count", 64'(decerr_count), 64'h3);

    $display("[TB] concurrent write port 0 and read port 1 with upstream stall");
    m_arready = 2'b11; m_rvalid = 2'b11; m_rdata = {32'hA5A50001, 32'h0BAD0BAD};
    m_rresp = 4'b1000;
    s0_bready = 0; s0_rready = 0;
    s0_awaddr = 8'h08; s0_awvalid = 1; s0_wdata = 32'h11223344; s0_wstrb = 4'hF; s0_wvalid = 1;
    s0_araddr = 8'h1C; s0_arvalid = 1;
    applyStimulus();
    s0_awvalid = 0; s0_wvalid = 0; s0_arvalid = 0;
    checkOutput("c_awvalid", 64'(m_awvalid), 64'h1);
    checkOutput("c_arvalid", 64'(m_arvalid), 64'h2);
    applyStimulus();
    applyStimulus();
    for (int k = 0; k < 4; k++) begin
      checkOutput("c_bvalid_hold", 64'(s0_bvalid), 64'h1);
      checkOutput("c_rvalid_hold", 64'(s0_rvalid), 64'h1);
      checkOutput("c_bresp_hold", 64'(s0_bresp), 64'h0);
      checkOutput("c_rresp_hold", 64'(s0_rresp), 64'h2);
      checkOutput("c_rdata_hold", 64'(s0_rdata), 64'hA5A50001);
      applyStimulus();
    end
    s0_bready = 1; s0_rready = 1;
    checkOutput("c_bvalid_accept", 64'(s0_bvalid), 64'h1);
    checkOutput("c_rvalid_accept", 64'(s0_rvalid), 64'h1);
    applyStimulus();
    checkOutput("c_bvalid_off", 64'(s0_bvalid), 64'h0);
    checkOutput("c_rvalid_off", 64'(s0_rvalid), 64'h0);
    checkOutput("c_count", 64'(decerr_count), 64'h3);

    $display("[TB] reset while waiting for B, then a fresh write");
    m_bvalid = 2'b00;
    s0_awaddr = 8'h10; s0_awvalid = 1; s0_wdata = 32'h0F0F0F0F; s0_wstrb = 4'hF; s0_wvalid = 1;
    applyStimulus();
    s0_awvalid = 0; s0_wvalid = 0;
    applyStimulus();
    checkOutput("x_bready", 64'(m_bready), 64'h2);
    reset = 1;
    applyStimulus();
    checkOutput("x_bready_rst", 64'(m_bready), 64'h0);
    checkOutput("x_ready_rst", 64'({s0_awready, s0_wready, s0_arready}), 64'h0);
    checkOutput("x_valid_rst", 64'({s0_bvalid, s0_rvalid}), 64'h0);
    checkOutput("x_count_rst", 64'(decerr_count), 64'h0);
    reset = 0;
    applyStimulus();
    checkOutput("x_awready", 64'(s0_awready), 64'h1);
    checkOutput("x_bvalid_none", 64'(s0_bvalid), 64'h0);
    m_bvalid = 2'b11;
    s0_awaddr = 8'h04; s0_awvalid = 1; s0_wdata = 32'h00000055; s0_wstrb = 4'h1; s0_wvalid = 1;
    applyStimulus();
    s0_awvalid = 0; s0_wvalid = 0;
    checkOutput("x_wdata", m_wdata, 64'h00000000_00000055);
    checkOutput("x_awvalid", 64'(m_awvalid), 64'h1);
    applyStimulus();
    applyStimulus();
    checkOutput("x_bvalid", 64'(s0_bvalid), 64'h1);
    checkOutput("x_bresp", 64'(s0_bresp), 64'h0);
    applyStimulus();
    checkOutput("x_bvalid_off", 64'(s0_bvalid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
